// File: rtl/jtag_pkg.sv
// jtag_pkg: TAP state encoding, default opcodes and decode strobes shared by the TAP controller
package jtag_pkg;
  typedef enum logic [3:0] {
    TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR,
    UPD_DR, SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR
  } tap_state_t;
  localparam logic [3:0] EXTEST_OP = 4'h0;
  localparam logic [3:0] SAMPLE_OP = 4'h1;
  localparam logic [3:0] IDCODE_OP = 4'h2;
  localparam logic [3:0] BYPASS_OP = 4'hF;
  localparam logic [3:0] IR_CAPTURE = 4'b0001;
  typedef struct packed {
    logic tlr;
    logic cap_dr;
    logic sh_dr;
    logic upd_dr;
    logic cap_ir;
    logic sh_ir;
    logic upd_ir;
  } tap_dec_t;
endpackage

// File: rtl/jtag_tap_fsm.sv
// jtag_tap_fsm: 16-state TAP state register, TMS next-state logic and one-hot state strobes
module jtag_tap_fsm
  import jtag_pkg::*;
(
  input  logic       CK,
  input  logic       TRST_N,
  input  logic       TMS,
  output logic [3:0] tap_state,
  output tap_dec_t   dec
);
  tap_state_t state, nxt;
  always_ff @(posedge CK)
    state <= !TRST_N ? TLR : nxt;
  always_comb begin
    nxt = state;
    case (state)
      TLR:     nxt = TMS ? TLR    : RTI;
      RTI:     nxt = TMS ? SEL_DR : RTI;
      SEL_DR:  nxt = TMS ? SEL_IR : CAP_DR;
      CAP_DR:  nxt = TMS ? EX1_DR : SH_DR;
      SH_DR:   nxt = TMS ? EX1_DR : SH_DR;
      EX1_DR:  nxt = TMS ? UPD_DR : PAU_DR;
      PAU_DR:  nxt = TMS ? EX2_DR : PAU_DR;
      EX2_DR:  nxt = TMS ? UPD_DR : SH_DR;
      UPD_DR:  nxt = TMS ? SEL_DR : RTI;
      SEL_IR:  nxt = TMS ? TLR    : CAP_IR;
      CAP_IR:  nxt = TMS ? EX1_IR : SH_IR;
      SH_IR:   nxt = TMS ? EX1_IR : SH_IR;
      EX1_IR:  nxt = TMS ? UPD_IR : PAU_IR;
      PAU_IR:  nxt = TMS ? EX2_IR : PAU_IR;
      EX2_IR:  nxt = TMS ? UPD_IR : SH_IR;
      UPD_IR:  nxt = TMS ? SEL_DR : RTI;
      default: nxt = TLR;
    endcase
  end
  always_comb begin
    tap_state  = state;
    dec.tlr    = state == TLR;
    dec.cap_dr = state == CAP_DR;
    dec.sh_dr  = state == SH_DR;
    dec.upd_dr = state == UPD_DR;
    dec.cap_ir = state == CAP_IR;
    dec.sh_ir  = state == SH_IR;
    dec.upd_ir = state == UPD_IR;
  end
endmodule

// File: rtl/jtag_tap_ctrl.sv
// jtag_tap_ctrl: TAP controller with IR, bypass and IDCODE registers, BSR strobes and TDO mux
module jtag_tap_ctrl
  import jtag_pkg::*;
#(
  parameter int              IR_W       = 4,
  parameter logic [31:0]     IDCODE_VAL = 32'h1923_4001,
  parameter logic [IR_W-1:0] OP_EXTEST  = EXTEST_OP,
  parameter logic [IR_W-1:0] OP_SAMPLE  = SAMPLE_OP,
  parameter logic [IR_W-1:0] OP_IDCODE  = IDCODE_OP,
  parameter logic [IR_W-1:0] OP_BYPASS  = BYPASS_OP
) (
  input  logic       CK,
  input  logic       TRST_N,
  input  logic       TMS,
  input  logic       TDI,
  input  logic       TDO_BSR,
  output logic       TDO,
  output logic       TDO_EN,
  output logic       clockdr,
  output logic       updatedr,
  output logic       shiftdr,
  output logic       bs_en,
  output logic [3:0] tap_state
);
  tap_dec_t          d;
  logic [IR_W-1:0]   ir_sh, ir_q;
  logic              byp;
  logic [31:0]       idcode_sh;
  logic              bsr_sel, idc_sel, byp_sel;
  jtag_tap_fsm u_fsm (
    .CK       (CK),
    .TRST_N   (TRST_N),
    .TMS      (TMS),
    .tap_state(tap_state),
    .dec      (d)
  );
  // OP_BYPASS is the catch-all: anything not BSR or IDCODE lands on the bypass bit
  assign bsr_sel = ir_q == OP_EXTEST || ir_q == OP_SAMPLE;
  assign idc_sel = !bsr_sel && ir_q == OP_IDCODE;
  assign byp_sel = !bsr_sel && !idc_sel;
  always_ff @(posedge CK) begin
    if (!TRST_N) begin
      ir_sh     <= '0;
      ir_q      <= OP_IDCODE;
      byp       <= 1'b0;
      idcode_sh <= '0;
    end else begin
      ir_sh     <= d.cap_ir ? IR_W'(IR_CAPTURE) : d.sh_ir ? {TDI, ir_sh[IR_W-1:1]} : ir_sh;
      ir_q      <= d.tlr ? OP_IDCODE : d.upd_ir ? ir_sh : ir_q;
      byp       <= !byp_sel ? byp : d.cap_dr ? 1'b0 : d.sh_dr ? TDI : byp;
      idcode_sh <= !idc_sel ? idcode_sh : d.cap_dr ? IDCODE_VAL : d.sh_dr ? {TDI, idcode_sh[31:1]} : idcode_sh;
    end
  end
  // bs_en is gated by TLR so a TMS-driven reset drops it before ir_q reloads
  always_comb begin
    TDO_EN   = d.sh_dr || d.sh_ir;
    shiftdr  = d.sh_dr;
    clockdr  = bsr_sel && (d.cap_dr || d.sh_dr);
    updatedr = bsr_sel && d.upd_dr;
    bs_en    = ir_q == OP_EXTEST && !d.tlr;
    TDO      = d.sh_ir ? ir_sh[0] : !d.sh_dr ? 1'b0 : bsr_sel ? TDO_BSR : idc_sel ? idcode_sh[0] : byp;
  end
endmodule

// File: doc/jtag_tap_ctrl.md
# jtag_tap_ctrl

IEEE 1149.1-style TAP controller that sequences the boundary-scan register (BSR) wrapped around the s9234 core. It decodes TMS into the 16-state TAP FSM, holds a 4-bit instruction register, and generates the `clockdr`, `updatedr`, `shiftdr` and `bs_en` controls consumed by the BSR chain. It also owns the bypass and IDCODE data registers and muxes the selected serial output onto `TDO`. It runs on the same single clock as the BSR; scan strobes are synchronous enables, not derived clocks.

## Interface
- `IR_W`, default 4: instruction register width.
- `IDCODE_VAL`, default 32'h1923_4001: device ID; bit 0 must be 1.
- `OP_EXTEST`, default 4'h0: BSR selected, `bs_en`=1.
- `OP_SAMPLE`, default 4'h1: BSR selected, `bs_en`=0.
- `OP_IDCODE`, default 4'h2: IDCODE register selected.
- `OP_BYPASS`, default 4'hF: bypass register selected. Any undefined opcode behaves as BYPASS.

Ports:
- `CK` in 1: sole clock; all state updates on its rising edge.
- `TRST_N` in 1: reset, synchronous, active-low.
- `TMS` in 1: TAP mode select, sampled on `CK`.
- `TDI` in 1: serial data in; also drives the BSR head.
- `TDO_BSR` in 1: serial output of the BSR tail.
- `TDO` out 1: selected serial output.
- `TDO_EN` out 1: high in SHIFT_DR/SHIFT_IR.
- `clockdr` out 1: BSR capture/shift enable.
- `updatedr` out 1: BSR update strobe.
- `shiftdr` out 1: BSR shift-vs-capture select.
- `bs_en` out 1: BSR drives core/pins from update latches.
- `tap_state` out 4: current FSM state, for debug and verification.

## Operation
- FSM states and TMS=0/TMS=1 successors:
  - TLR → RTI/TLR
  - RTI → RTI/SEL_DR
  - SEL_DR → CAP_DR/SEL_IR
  - CAP_DR → SH_DR/EX1_DR
  - SH_DR → SH_DR/EX1_DR
  - EX1_DR → PAU_DR/UPD_DR
  - PAU_DR → PAU_DR/EX2_DR
  - EX2_DR → SH_DR/UPD_DR
  - UPD_DR → RTI/SEL_DR
  - SEL_IR → CAP_IR/TLR
  - CAP_IR → SH_IR/EX1_IR
  - SH_IR → SH_IR/EX1_IR
  - EX1_IR → PAU_IR/UPD_IR
  - PAU_IR → PAU_IR/EX2_IR
  - EX2_IR → SH_IR/UPD_IR
  - UPD_IR → RTI/SEL_DR
- Encoding is fixed, 0..15 in the order listed (TLR=0, RTI=1, … UPD_IR=15).
- IR: shift register `ir_sh` and active `ir_q`.
  - CAP_IR loads `ir_sh`=4'b0001.
  - SH_IR shifts right with TDI entering the MSB; the LSB goes to `TDO`.
  - UPD_IR copies `ir_sh` to `ir_q`.
  - In TLR, `ir_q`=OP_IDCODE.
- Bypass register: 1 bit. Captures 0 in CAP_DR when selected; in SH_DR, takes TDI and drives `TDO`.
- IDCODE register: 32 bits. Loads IDCODE_VAL in CAP_DR when selected; in SH_DR, shifts right with TDI into the MSB and the LSB to `TDO`.
- BSR controls, Moore decodes of `tap_state` and `ir_q`, where `bsr_sel` = (`ir_q`==EXTEST or SAMPLE):
  - `clockdr` = `bsr_sel` and state ∈ {CAP_DR, SH_DR}.
  - `shiftdr` = (state==SH_DR).
  - `updatedr` = `bsr_sel` and state==UPD_DR.
  - `bs_en` = (`ir_q`==EXTEST); level, held across DR scans, cleared in TLR.
- `TDO` mux:
  - SH_IR → `ir_sh[0]`.
  - SH_DR → LSB of the selected register (`TDO_BSR`, bypass bit or `idcode_sh[0]`).
  - Otherwise 0.
  - Combinational from registered state.

## Timing
- Reset: `TRST_N`=0 at a `CK` edge forces TLR, `ir_q`=OP_IDCODE, `ir_sh`=0, bypass=0, `idcode_sh`=0.
  - All outputs then read 0, except `tap_state`=0.
  - Reset overrides any in-flight scan; no UPD_* side effect occurs.
- Independent of `TRST_N`, five consecutive TMS=1 edges reach TLR from any state.
- Each FSM transition takes one `CK` edge. Decoded outputs are valid in the cycle the state is entered and act on the next edge.
- Capture happens on the edge leaving CAP_DR/CAP_IR. Each SH_* cycle shifts one bit on its edge, including the edge that exits to EX1_*.
- Bypass: with BYPASS loaded, `TDO` equals TDI delayed exactly one SH_DR cycle.
- `ir_q` changes on the edge leaving UPD_IR. New `bs_en` is visible in the following state (RTI or SEL_DR).
- Pause states hold all shift registers unchanged.

## Structure
- Package `jtag_pkg`:
  - `tap_state_t` enum (16 states, fixed encoding).
  - Opcode localparams.
  - `IR_CAPTURE` = 4'b0001.
- Sub-module `jtag_tap_fsm`: state register and next-state logic only. It exports `tap_state` and one-hot decode strobes.
- `jtag_tap_ctrl` holds the IR, bypass, IDCODE, output decode and `TDO` mux.

## Test plan
- `TRST_N` low 1 cycle mid-SH_DR → `tap_state`=0, `bs_en`=0, `ir_q`=4'h2, `TDO`=0 next cycle.
- From RTI, TMS=1,1,1,1,1 → `tap_state`=0 after the 5th edge. Repeat from SH_IR and PAU_DR.
- Reset, TMS to SH_DR, shift 32 bits → `TDO` sequence LSB-first equals 32'h1923_4001.
- Load IR 4'h0 (TDI 0,0,0,0) → SH_IR emits 1,0,0,0. After UPD_IR, `bs_en`=1. A DR scan raises `clockdr` in CAP_DR+SH_DR, `updatedr` exactly one cycle in UPD_DR, and `TDO` follows `TDO_BSR`.
- Load IR 4'hF, shift TDI 1,0,1,1 → `TDO` = 0,1,0,1 (one-cycle delay, leading captured 0). `clockdr`/`updatedr` never assert.
- Load IR 4'h7 (undefined) → behaves as BYPASS. Then SAMPLE 4'h1 → `clockdr` active, `bs_en`=0.
